// File: rtl/bcd_disp_mux.sv
// Four-digit time-multiplexed common-anode seven-segment driver with per-frame input snapshot.
// Optional leading-zero blanking is compiled in when LEADING_ZERO_BLANK_EN is defined.
module bcd_disp_mux #(
  parameter int N = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  logic [N-1:0] q_q, q_d;
  logic [3:0]   dig_q [4];
  logic [3:0]   dig_d [4];
  logic [3:0]   dp_q, dp_d;
  logic [3:0]   an_q, an_d;
  logic [7:0]   sseg_q, sseg_d;
  logic [1:0]   sel;
  logic [3:0]   curDigit;
  logic         blank;

  assign sel = q_q[N-1:N-2];

  function automatic logic [6:0] segDecode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Counter free-runs; shadows reload only at frame start so a scan never mixes two values.
  always_comb begin
    q_d  = q_q + {{(N-1){1'b0}}, 1'b1};
    dp_d = dp_q;
    for (int i = 0; i < 4; i++) dig_d[i] = dig_q[i];
    if (q_q == '0) begin
      dig_d[0] = d0;
      dig_d[1] = d1;
      dig_d[2] = d2;
      dig_d[3] = d3;
      dp_d     = dp_in;
    end
  end

  always_comb begin
    curDigit = dig_q[sel];
`ifdef LEADING_ZERO_BLANK_EN
    case (sel)
      2'd3:    blank = (dig_q[3] == 4'd0);
      2'd2:    blank = (dig_q[3] == 4'd0) && (dig_q[2] == 4'd0);
      2'd1:    blank = (dig_q[3] == 4'd0) && (dig_q[2] == 4'd0) && (dig_q[1] == 4'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    an_d        = ~(4'b0001 << sel);
    sseg_d[7]   = ~dp_q[sel];
    sseg_d[6:0] = blank ? 7'h7F : segDecode(curDigit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      dp_q   <= '0;
      an_q   <= 4'b1111;
      sseg_q <= 8'hFF;
      for (int i = 0; i < 4; i++) dig_q[i] <= '0;
    end else begin
      q_q    <= q_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
      for (int i = 0; i < 4; i++) dig_q[i] <= dig_d[i];
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule
